sum_stream_src: RTL and testbench

Stimulus-side initiator for the `sumItUp` add-stream protocol. It holds a programmable list of up to `DEPTH` operands and streams them on `valueOut` with the `go_l` start strobe. It then waits for the adder's `done`, captures its `sumIn`, and checks it against an internally computed expected sum. It sits upstream of the adder, in place of the bench-driven stimulus, and reports the result on `match`/`resultValid`.

---
 rtl/sum_stream_src.sv | 134 +++++++++++++
 tb/tb_sum_stream_src.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sum_stream_src.sv
// Stimulus-side initiator for the add-stream protocol: streams a programmable
// operand list, waits for the adder's done, and compares its sum to a local one.
module sum_stream_src #(
  parameter int W       = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic          ck,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  output logic [W-1:0]  valueOut,
  output logic          go_l,
  input  logic          done,
  input  logic [W-1:0]  sumIn,
  output logic          busy,
  output logic [W-1:0]  expSum,
  output logic          resultValid,
  output logic          match,
  output logic          timeout
);

  // state | meaning
  // IDLE  | list writable, waiting for start
  // SEND  | driving list[idx] on valueOut
  // TERM  | forced zero terminator after a full list
  // WAIT  | waiting for done, wait counter running
  typedef enum logic [1:0] {IDLE, SEND, TERM, WAIT} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt, idx_inc;
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic [W-1:0]  list [DEPTH];
  logic [W-1:0]  value_nxt, exp_nxt;
  logic          go_nxt, busy_nxt, rv_nxt, match_nxt, to_nxt;

  assign idx_inc = idx + 1'b1;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    value_nxt = 8'(0) == 0 ? '0 : '0;
    exp_nxt   = expSum;
    go_nxt    = 1'b1;
    busy_nxt  = busy;
    rv_nxt    = 1'b0;
    match_nxt = match;
    to_nxt    = timeout;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          value_nxt = list[0];
          go_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          exp_nxt   = list[0];
          match_nxt = 1'b0;
          to_nxt    = 1'b0;
        end
      end
      SEND: begin
        if (list[idx] == '0) begin
          state_nxt = WAIT;
          wcnt_nxt  = CW'(TIMEOUT - 1);
        end else if (idx == AW'(DEPTH - 1)) begin
          state_nxt = TERM;
        end else begin
          idx_nxt   = idx_inc;
          value_nxt = list[idx_inc];
          exp_nxt   = expSum + list[idx_inc];
        end
      end
      TERM: begin
        state_nxt = WAIT;
        wcnt_nxt  = CW'(TIMEOUT - 1);
      end
      WAIT: begin
        // done takes priority over an expiring wait count
        if (done) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          rv_nxt    = 1'b1;
          match_nxt = (sumIn == expSum);
        end else if (wcnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          rv_nxt    = 1'b1;
          match_nxt = 1'b0;
          to_nxt    = 1'b1;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      wcnt        <= '0;
      valueOut    <= '0;
      go_l        <= 1'b1;
      busy        <= 1'b0;
      expSum      <= '0;
      resultValid <= 1'b0;
      match       <= 1'b0;
      timeout     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) list[i] <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      wcnt        <= wcnt_nxt;
      valueOut    <= value_nxt;
      go_l        <= go_nxt;
      busy        <= busy_nxt;
      expSum      <= exp_nxt;
      resultValid <= rv_nxt;
      match       <= match_nxt;
      timeout     <= to_nxt;
      if (state == IDLE && wr_en) list[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sum_stream_src.sv
// Directed bench for sum_stream_src: streams, sums, match, timeout, ignored inputs, reset.
module tb_sum_stream_src;
  localparam int W = 8, DEPTH = 8, TIMEOUT = 64, AW = 3;

  logic          ck = 1'b0;
  logic          reset;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          start = 1'b0;
  logic [W-1:0]  valueOut;
  logic          go_l;
  logic          done = 1'b0;
  logic [W-1:0]  sumIn = '0;
  logic          busy;
  logic [W-1:0]  expSum;
  logic          resultValid;
  logic          match;
  logic          timeout;

  int total = 0;
  int bad   = 0;
  int exp_words [9];

  sum_stream_src #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ck(ck), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .valueOut(valueOut), .go_l(go_l), .done(done), .sumIn(sumIn),
    .busy(busy), .expSum(expSum), .resultValid(resultValid), .match(match),
    .timeout(timeout)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic write_entry(input int addr, input int data);
    @(negedge ck);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = W'(data);
    @(negedge ck);
    wr_en = 1'b0;
  endtask

  // nw words expected on valueOut (terminator included); dly < 0 means done never comes
  task automatic run_stream(input int nw, input int dly, input int ret,
                            input int exp_sum, input bit exp_match, input bit inject);
    @(negedge ck); start = 1'b1;
    @(negedge ck); start = 1'b0;
    chk("word0", valueOut, exp_words[0]);
    chk("go_l_first", go_l, 0);
    chk("busy_run", busy, 1);
    chk("timeout_cleared", timeout, 0);
    chk("match_cleared", match, 0);
    if (inject) begin
      start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'd9;
    end
    for (int k = 1; k < nw; k++) begin
      @(negedge ck);
      start = 1'b0; wr_en = 1'b0;
      chk($sformatf("word%0d", k), valueOut, exp_words[k]);
      chk($sformatf("go_l%0d", k), go_l, 1);
    end
    start = 1'b0; wr_en = 1'b0;
    if (dly >= 0) begin
      repeat (dly) begin
        @(negedge ck);
        chk("rv_wait", resultValid, 0);
        chk("value_wait", valueOut, 0);
      end
      done = 1'b1; sumIn = W'(ret);
      @(negedge ck);
      done = 1'b0;
      chk("rv_done", resultValid, 1);
      chk("match_done", match, exp_match);
      chk("busy_done", busy, 0);
      chk("expSum", expSum, exp_sum);
      chk("timeout_done", timeout, 0);
    end else begin
      repeat (TIMEOUT) @(negedge ck);
      chk("rv_pre_to", resultValid, 0);
      chk("timeout_pre", timeout, 0);
      @(negedge ck);
      chk("rv_to", resultValid, 1);
      chk("timeout_set", timeout, 1);
      chk("match_to", match, 0);
      chk("busy_to", busy, 0);
      chk("expSum_to", expSum, exp_sum);
    end
    @(negedge ck);
    chk("rv_single", resultValid, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge ck);
    reset = 1'b0;
    @(negedge ck);
    chk("rst_go_l", go_l, 1);
    chk("rst_value", valueOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_expSum", expSum, 0);
    chk("rst_rv", resultValid, 0);
    chk("rst_match", match, 0);
    chk("rst_timeout", timeout, 0);

    // done while idle
    done = 1'b1;
    @(negedge ck);
    done = 1'b0;
    chk("idle_done_rv", resultValid, 0);
    @(negedge ck);
    chk("idle_done_rv2", resultValid, 0);

    write_entry(0, 3); write_entry(1, 5); write_entry(2, 7); write_entry(3, 0);
    exp_words = '{3, 5, 7, 0, 0, 0, 0, 0, 0};
    run_stream(4, 2, 15, 15, 1'b1, 1'b1);
    run_stream(4, 2, 14, 15, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) write_entry(i, 200);
    exp_words = '{200, 200, 200, 200, 200, 200, 200, 200, 0};
    run_stream(9, 1, 64, 64, 1'b1, 1'b0);
    run_stream(9, -1, 0, 64, 1'b0, 1'b0);
    run_stream(9, 3, 64, 64, 1'b1, 1'b0);

    // reset mid-stream
    @(negedge ck); start = 1'b1;
    @(negedge ck); start = 1'b0;
    @(negedge ck);
    chk("mid_value", valueOut, 200);
    reset = 1'b1;
    #1;
    chk("arst_value", valueOut, 0);
    chk("arst_go_l", go_l, 1);
    chk("arst_busy", busy, 0);
    chk("arst_expSum", expSum, 0);
    @(negedge ck);
    reset = 1'b0;

    // list cleared, so entry 0 is the terminator
    exp_words = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_stream(1, 2, 0, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
